// File: rtl/demux_deser_14.sv
// demux_deser_14: serial-to-parallel 1:4 bit demultiplexer for the ZigBee receive bit path.
// It collects four accepted bits into a nibble, presents the nibble on a valid/ready output,
// supports a frame-start resync, and flags aborted partial nibbles and dropped bits.
module demux_deser_14 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       inClk,
  input  logic       inResetb,
  input  logic       inData,
  input  logic       inValid,
  input  logic       inStart,
  input  logic       inClrOvf,
  input  logic       inReady,
  output logic       outReady,
  output logic [3:0] outData,
  output logic       outValid,
  output logic [1:0] outSel,
  output logic       outAbort,
  output logic       outOverflow
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [IDX_W-1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [NIB_W-1:0]   acc_q, acc_d;
  logic [NIB_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               abort_q, abort_d;
  logic               ovf_q, ovf_d;

  logic               ready_c;
  logic               accept_c;
  logic               xfer_c;
  logic               drop_c;

  // Nibble bit position that receives the bit accepted at index k.
  function automatic logic [IDX_W-1:0] map_idx(input logic [IDX_W-1:0] k);
    if (LSB_FIRST) begin
      return k;
    end
    return IDX_W'(2'd3 - k);
  endfunction

  // Handshake qualifiers; only the completing bit stalls while the output is still full.
  always_comb begin
    ready_c  = !((state_q == S3) && valid_q && !inReady);
    accept_c = inValid && ready_c;
    xfer_c   = valid_q && inReady;
    drop_c   = inValid && !ready_c && !inStart;
  end

  // State register: bit index.
  always_ff @(posedge inClk or negedge inResetb) begin
    if (!inResetb) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: frame start resyncs the index, otherwise advance (with wrap) on accept.
  always_comb begin
    state_d = state_q;
    if (inStart) begin
      state_d = inValid ? S1 : S0;
    end else if (accept_c) begin
      state_d = state_t'(IDX_W'(state_q + 2'd1));
    end
  end

  // Datapath/output next values: accumulate, complete, handshake, abort and overflow.
  always_comb begin
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    abort_d = 1'b0;
    ovf_d   = ovf_q;

    if (xfer_c) begin
      valid_d = 1'b0;
    end

    // Drop sets after clear so a simultaneous drop keeps the flag high.
    if (inClrOvf) begin
      ovf_d = 1'b0;
    end
    if (drop_c) begin
      ovf_d = 1'b1;
    end

    if (inStart) begin
      abort_d = (state_q != S0);
      acc_d   = '0;
      if (inValid) begin
        acc_d[map_idx(S0)] = inData;
      end
    end else if (accept_c) begin
      if (state_q == S3) begin
        data_d              = acc_q;
        data_d[map_idx(S3)] = inData;
        valid_d             = 1'b1;
        acc_d               = '0;
      end else begin
        acc_d[map_idx(state_q)] = inData;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge inClk or negedge inResetb) begin
    if (!inResetb) begin
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
    end
  end

  // Port drive; outReady is the only combinational output and depends on inReady alone.
  always_comb begin
    outReady    = ready_c;
    outData     = data_q;
    outValid    = valid_q;
    outSel      = state_q;
    outAbort    = abort_q;
    outOverflow = ovf_q;
  end

endmodule

// File: tb/tb_demux_deser_14.sv
// Testbench for demux_deser_14: directed bit streams, expected nibbles queued per instance,
// monitors pop and compare on every output transfer; control outputs checked inline.
module tb_demux_deser_14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_data, in_valid, in_start, in_clr_ovf, in_ready;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic [1:0] out_sel;
  logic       out_abort, out_ovf;

  logic       in_data1, in_valid1;
  logic       out_ready1;
  logic [3:0] out_data1;
  logic       out_valid1;
  logic [1:0] out_sel1;
  logic       out_abort1, out_ovf1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int xfer_cyc[$];

  demux_deser_14 #(.LSB_FIRST(1'b1)) dut0 (
    .inClk(clk), .inResetb(rst_n), .inData(in_data), .inValid(in_valid),
    .inStart(in_start), .inClrOvf(in_clr_ovf), .inReady(in_ready),
    .outReady(out_ready), .outData(out_data), .outValid(out_valid),
    .outSel(out_sel), .outAbort(out_abort), .outOverflow(out_ovf)
  );

  demux_deser_14 #(.LSB_FIRST(1'b0)) dut1 (
    .inClk(clk), .inResetb(rst_n), .inData(in_data1), .inValid(in_valid1),
    .inStart(1'b0), .inClrOvf(1'b0), .inReady(1'b1),
    .outReady(out_ready1), .outData(out_data1), .outValid(out_valid1),
    .outSel(out_sel1), .outAbort(out_abort1), .outOverflow(out_ovf1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  // Monitor for the LSB-first instance: compare every transfer against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && in_ready) begin
      xfer_cyc.push_back(cyc);
      if (q0.size() == 0) begin
        chk("dut0_unexpected_nibble", {28'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("dut0_nibble", {28'd0, out_data}, {28'd0, q0.pop_front()});
      end
    end
  end

  // Monitor for the MSB-first instance (downstream always ready).
  always @(negedge clk) begin
    if (rst_n && out_valid1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_nibble", {28'd0, out_data1}, 32'hFFFF_FFFF);
      end else begin
        chk("dut1_nibble", {28'd0, out_data1}, {28'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  nib;
    logic [15:0] stream;
    rst_n = 1'b0; in_data = 0; in_valid = 0; in_start = 0; in_clr_ovf = 0; in_ready = 1;
    in_data1 = 0; in_valid1 = 0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_abort", 32'(out_abort), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ready", 32'(out_ready), 32'd1);
    #10 rst_n = 1'b1;
    step();

    // Single nibble 1,0,1,1 -> D
    nib = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      chk("t1_sel", 32'(out_sel), 32'(i));
      if (i == 3) q0.push_back(4'hD);
      bit_in(nib[i]);
    end
    chk("t1_sel_wrap", 32'(out_sel), 32'd0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hD);
    step();
    chk("t1_valid_pulse", 32'(out_valid), 32'd0);

    // Continuous stream: nibbles D,0,F,2 four cycles apart
    xfer_cyc.delete();
    stream = 16'b0010_1111_0000_1101;
    for (int i = 0; i < 16; i++) begin
      if (i == 3)  q0.push_back(4'hD);
      if (i == 7)  q0.push_back(4'h0);
      if (i == 11) q0.push_back(4'hF);
      if (i == 15) q0.push_back(4'h2);
      in_valid = 1'b1;
      in_data  = stream[i];
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t2_xfer_count", 32'(xfer_cyc.size()), 32'd4);
    if (xfer_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("t2_spacing", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd4);
    end

    // Stall: first nibble 0,1,1,0 -> 6 held; 8th bit stalled and dropped twice
    in_ready = 1'b0;
    q0.push_back(4'h6);
    nib = 4'b0110;
    for (int i = 0; i < 4; i++) bit_in(nib[i]);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_data", 32'(out_data), 32'h6);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
    chk("t3_sel3", 32'(out_sel), 32'd3);
    in_valid = 1'b1; in_data = 1'b1;
    #1;
    chk("t3_ready_low", 32'(out_ready), 32'd0);
    step();
    chk("t3_ovf", 32'(out_ovf), 32'd1);
    chk("t3_sel_hold", 32'(out_sel), 32'd3);
    chk("t3_data_hold", 32'(out_data), 32'h6);
    step();
    chk("t3_sel_hold2", 32'(out_sel), 32'd3);
    q0.push_back(4'h9);
    in_ready = 1'b1;
    #1;
    chk("t3_ready_high", 32'(out_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t3_valid_b2b", 32'(out_valid), 32'd1);
    chk("t3_data_new", 32'(out_data), 32'h9);
    chk("t3_sel_wrap", 32'(out_sel), 32'd0);
    chk("t3_ovf_sticky", 32'(out_ovf), 32'd1);
    in_clr_ovf = 1'b1;
    step();
    in_clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(out_ovf), 32'd0);

    // Frame start mid-nibble: abort, then resync to 1,0,0,1 -> 9
    bit_in(1'b1); bit_in(1'b1);
    chk("t4_sel2", 32'(out_sel), 32'd2);
    in_start = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    step();
    in_start = 1'b0; in_valid = 1'b0;
    chk("t4_abort", 32'(out_abort), 32'd1);
    chk("t4_sel1", 32'(out_sel), 32'd1);
    bit_in(1'b0);
    chk("t4_abort_pulse", 32'(out_abort), 32'd0);
    bit_in(1'b0);
    q0.push_back(4'h9);
    bit_in(1'b1);
    chk("t4_sel0", 32'(out_sel), 32'd0);
    chk("t4_data", 32'(out_data), 32'h9);
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    chk("t4_no_abort", 32'(out_abort), 32'd0);
    chk("t4_sel_start0", 32'(out_sel), 32'd0);

    // MSB-first instance: 1,0,0,0 -> 8
    nib = 4'b0001;
    q1.push_back(4'h8);
    for (int i = 0; i < 4; i++) begin
      in_valid1 = 1'b1;
      in_data1  = nib[i];
      step();
    end
    in_valid1 = 1'b0;
    chk("t5_data", 32'(out_data1), 32'h8);
    step();

    // Async reset with pending nibble and index 2
    in_ready = 1'b0;
    nib = 4'b0001;
    for (int i = 0; i < 4; i++) bit_in(nib[i]);
    bit_in(1'b1); bit_in(1'b1);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_sel", 32'(out_sel), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    chk("t6_rst_sel", 32'(out_sel), 32'd0);
    chk("t6_rst_abort", 32'(out_abort), 32'd0);
    chk("t6_rst_ovf", 32'(out_ovf), 32'd0);
    #3 rst_n = 1'b1;
    step();
    in_ready = 1'b1;
    q0.push_back(4'h3);
    nib = 4'b0011;
    for (int i = 0; i < 4; i++) bit_in(nib[i]);
    chk("t6_data", 32'(out_data), 32'h3);
    chk("t6_abort_none", 32'(out_abort), 32'd0);
    step();
    step();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_deser_14.md
Name: demux_deser_14

Overview:
Serial-to-parallel 1:4 demultiplexer for the ZigBee bit path. It is the receive-side counterpart of the 4:1 bit selector. It collects four serial bits into a 4-bit symbol nibble, with a valid/ready handshake on the output. It accepts a frame-start resync and reports aborted and overflowed bits. It sits between the bit slicer and the symbol-to-chip / symbol-decode stages.

Parameters:
LSB_FIRST, 1, 1: first accepted bit goes to nibble bit 0 (index 00 first); 0: first accepted bit goes to bit 3.

Ports:
inClk  input  1  clock, rising-edge.
inResetb  input  1  asynchronous active-low reset.
inData  input  1  serial bit.
inValid  input  1  inData is valid this cycle.
inStart  input  1  frame start; resynchronises the bit index.
inClrOvf  input  1  synchronous clear of outOverflow.
inReady  input  1  downstream accepts outData when outValid=1.
outReady  output  1  upstream may present a bit (combinational).
outData  output  4  assembled nibble.
outValid  output  1  outData holds a complete nibble.
outSel  output  2  index the next accepted bit will be written to.
outAbort  output  1  one-cycle pulse: a partial nibble was discarded.
outOverflow  output  1  sticky: a bit was dropped under stall.

Behaviour:
- Reset (inResetb=0, async): index=0, accumulator=0, outData=0, outValid=0, outAbort=0, outOverflow=0. outReady reads 1 after reset.
- State is the 2-bit index: S0, S1, S2, S3. Accept = inValid & outReady.
- Accept in Sk (k<3): acc[map(k)] <= inData; next state is Sk+1. map(k)=k if LSB_FIRST=1, else 3-k.
- Accept in S3:
  - outData <= {acc with map(3)=inData}; outValid <= 1.
  - Next state S0 (wrap-around); acc cleared.
  - Latency: nibble is visible the cycle after the 4th bit's edge.
- Output handshake:
  - Transfer occurs on outValid & inReady.
  - outValid and outData stay stable until transfer.
  - On transfer without a new completion, outValid <= 0.
  - Transfer and completion in the same cycle: outValid stays 1 and outData takes the new nibble, so back-to-back nibbles every 4 cycles incur no bubble.
- outReady = !(state==S3 & outValid & !inReady).
  - Bits for S0..S2 are always accepted while the output is full.
  - Only the completing bit is stalled.
- Overflow: inValid=1 while outReady=0 (and inStart=0) drops the bit and leaves the index unchanged. outOverflow <= 1 next cycle.
  - Cleared only by inClrOvf or reset.
  - inClrOvf and a new drop in the same cycle: the flag remains 1 (set wins).
- inStart (highest priority):
  - If the index is not 0, outAbort pulses 1 next cycle and the partial nibble is discarded. No abort when the index is 0.
  - With inValid=1: the bit is written to map(0) regardless of outReady, and the next state is S1.
  - With inValid=0: the next state is S0 and acc is cleared.
  - inStart never alters outValid/outData: a pending nibble is preserved.
- outSel = current index (registered).
- Reset asserted mid-nibble or with outValid=1: everything is cleared immediately. The pending nibble is lost and no abort or overflow is reported.
- No combinational path from inData to any output. outReady depends combinationally on inReady only.

Test Plan:
- LSB_FIRST=1, inReady=1, bits 1,0,1,1 on 4 consecutive cycles -> outData=4'hD with outValid=1 for exactly 1 cycle, one cycle after the 4th bit; outSel sequence 0,1,2,3,0.
- Continuous stream 16 bits (1,0,1,1, 0,0,0,0, 1,1,1,1, 0,1,0,0), inReady=1 -> nibbles D, 0, F, 2, each with outValid pulses spaced exactly 4 cycles apart and no bubbles.
- inReady=0, stream 8 bits -> first nibble held stable; outReady=0 when in S3 with the 8th bit presented. Keep inValid=1 for 2 cycles -> outOverflow=1 and outSel stays 3. Raise inReady -> transfer, then the 8th bit is accepted. inClrOvf -> outOverflow=0.
- After 2 bits (outSel=2), assert inStart with inValid=1, bit 1 -> outAbort pulses 1 cycle and outSel=1. Following bits 0,0,1 -> outData=4'h9. inStart at outSel=0 -> no abort.
- LSB_FIRST=0, bits 1,0,0,0 -> outData=4'h8.
- Assert inResetb=0 asynchronously (between clock edges) at outSel=2 with outValid=1 -> all outputs 0 immediately; after release, bits 1,1,0,0 -> outData=4'h3.
